// File: rtl/lcd_msg_arbiter.sv
// Priority arbiter that picks which requester's message code the LCD shows,
// holding each granted message for a fixed time and letting higher priorities cut in.
module lcd_msg_arbiter #(
    parameter int unsigned HOLD_CYCLES = 100000000,
    parameter logic [4:0]  IDLE_CODE   = 5'd0
) (
    input  logic       iCLK_50MHZ,
    input  logic       iRST_N,
    input  logic [3:0] req,
    input  logic [4:0] code0,
    input  logic [4:0] code1,
    input  logic [4:0] code2,
    input  logic [4:0] code3,
    output logic [4:0] state_code,
    output logic [3:0] grant,
    output logic       busy,
    output logic       done,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        RELEASE
    } state_t;

    localparam logic [26:0] LOAD_VALUE = 27'(HOLD_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  pend;
    logic [3:0]  pend_next;
    logic [26:0] count;
    logic [26:0] count_next;
    logic [4:0]  code_next;
    logic [3:0]  grant_next;
    logic        busy_next;
    logic        done_next;
    logic        preempt_next;
    logic [1:0]  winner;
    logic [3:0]  winner_mask;
    logic [4:0]  winner_code;
    logic        do_grant;
    logic        take_over;

    always_comb begin
        winner      = 2'd0;
        winner_mask = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            if (pend[i]) begin
                winner      = 2'(i);
                winner_mask = 4'(1 << i);
            end
        end
        case (winner)
            2'd0:    winner_code = code0;
            2'd1:    winner_code = code1;
            2'd2:    winner_code = code2;
            default: winner_code = code3;
        endcase
    end

    // grant is one-hot in SHOW, so grant-1 masks exactly the higher-priority slots
    assign take_over = (state == SHOW) && ((pend & (grant - 4'd1)) != 4'b0000);

    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        case (state)
            IDLE: begin
                if (pend != 4'b0000) begin
                    state_next = SHOW;
                    do_grant   = 1'b1;
                end
            end
            SHOW: begin
                if (take_over) begin
                    do_grant = 1'b1;
                end else if (count == 27'd0) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (pend != 4'b0000) begin
                    state_next = SHOW;
                    do_grant   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pend_next    = pend;
        count_next   = count;
        code_next    = state_code;
        grant_next   = grant;
        done_next    = 1'b0;
        preempt_next = take_over;
        busy_next    = (state_next == SHOW);
        if (do_grant) begin
            grant_next = winner_mask;
            code_next  = winner_code;
            count_next = LOAD_VALUE;
            pend_next  = (pend & ~winner_mask) | (take_over ? grant : 4'b0000);
        end else if (state == SHOW) begin
            if (count == 27'd0) begin
                grant_next = 4'b0000;
                done_next  = 1'b1;
            end else begin
                count_next = count - 27'd1;
            end
        end else if (state == RELEASE) begin
            code_next = IDLE_CODE;
        end
        // a request seen on the same edge always survives any clear
        pend_next = pend_next | req;
    end

    always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
        if (!iRST_N) begin
            pend       <= 4'b0000;
            count      <= 27'd0;
            state_code <= IDLE_CODE;
            grant      <= 4'b0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            preempt    <= 1'b0;
        end else begin
            pend       <= pend_next;
            count      <= count_next;
            state_code <= code_next;
            grant      <= grant_next;
            busy       <= busy_next;
            done       <= done_next;
            preempt    <= preempt_next;
        end
    end

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Directed bench for lcd_msg_arbiter with an 8-cycle hold: vector table for
// single/simultaneous/low-priority traffic, hand sequences for preempt, tie, level hold, reset.
module tb_lcd_msg_arbiter;

    logic       iCLK_50MHZ = 1'b0;
    logic       iRST_N;
    logic [3:0] req;
    logic [4:0] code0;
    logic [4:0] code1;
    logic [4:0] code2;
    logic [4:0] code3;
    logic [4:0] state_code;
    logic [3:0] grant;
    logic       busy;
    logic       done;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic [4:0] c2;
        logic [3:0] g;
        logic [4:0] sc;
        logic       b;
        logic       d;
        logic       p;
        string      name;
    } vec_t;

    vec_t vecs[$];

    lcd_msg_arbiter #(
        .HOLD_CYCLES(8),
        .IDLE_CODE(5'd0)
    ) dut (
        .iCLK_50MHZ(iCLK_50MHZ),
        .iRST_N(iRST_N),
        .req(req),
        .code0(code0),
        .code1(code1),
        .code2(code2),
        .code3(code3),
        .state_code(state_code),
        .grant(grant),
        .busy(busy),
        .done(done),
        .preempt(preempt)
    );

    always #10 iCLK_50MHZ = ~iCLK_50MHZ;

    task automatic applyStimulus(input logic [3:0] r);
        req = r;
        @(posedge iCLK_50MHZ);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] g, input logic [4:0] sc,
                               input logic b, input logic d, input logic p);
        checks++;
        if ({grant, state_code, busy, done, preempt} !== {g, sc, b, d, p}) begin
            errors++;
            $display("[TB] FAIL %s: got grant=%b code=%0d busy=%b done=%b preempt=%b, want grant=%b code=%0d busy=%b done=%b preempt=%b",
                     name, grant, state_code, busy, done, preempt, g, sc, b, d, p);
        end
    endtask

    task automatic addRows(input int n, input logic [3:0] r, input logic [4:0] c2,
                           input logic [3:0] g, input logic [4:0] sc,
                           input logic b, input logic d, input logic p, input string nm);
        for (int i = 0; i < n; i++) begin
            vecs.push_back('{req: r, c2: c2, g: g, sc: sc, b: b, d: d, p: p, name: nm});
        end
    endtask

    task automatic stepCheck(input int n, input logic [3:0] r, input string nm,
                             input logic [3:0] g, input logic [4:0] sc,
                             input logic b, input logic d, input logic p);
        for (int i = 0; i < n; i++) begin
            applyStimulus(r);
            checkOutput(nm, g, sc, b, d, p);
        end
    endtask

    initial begin
        iRST_N = 1'b0;
        req    = 4'b0000;
        code0  = 5'd1;
        code1  = 5'd3;
        code2  = 5'd7;
        code3  = 5'd9;

        // single pulse, code2 changes mid-show must not leak through
        addRows(1, 4'b0100, 5'd7,  4'b0000, 5'd0, 1'b0, 1'b0, 1'b0, "single_pend");
        addRows(1, 4'b0000, 5'd7,  4'b0100, 5'd7, 1'b1, 1'b0, 1'b0, "single_grant");
        addRows(3, 4'b0000, 5'd7,  4'b0100, 5'd7, 1'b1, 1'b0, 1'b0, "single_show");
        addRows(4, 4'b0000, 5'd21, 4'b0100, 5'd7, 1'b1, 1'b0, 1'b0, "single_codehold");
        addRows(1, 4'b0000, 5'd7,  4'b0000, 5'd7, 1'b0, 1'b1, 1'b0, "single_done");
        addRows(3, 4'b0000, 5'd7,  4'b0000, 5'd0, 1'b0, 1'b0, 1'b0, "single_idle");
        // simultaneous 1 and 3: 3 follows directly out of RELEASE
        addRows(1, 4'b1010, 5'd7,  4'b0000, 5'd0, 1'b0, 1'b0, 1'b0, "simul_pend");
        addRows(8, 4'b0000, 5'd7,  4'b0010, 5'd3, 1'b1, 1'b0, 1'b0, "simul_show1");
        addRows(1, 4'b0000, 5'd7,  4'b0000, 5'd3, 1'b0, 1'b1, 1'b0, "simul_done1");
        addRows(8, 4'b0000, 5'd7,  4'b1000, 5'd9, 1'b1, 1'b0, 1'b0, "simul_show3");
        addRows(1, 4'b0000, 5'd7,  4'b0000, 5'd9, 1'b0, 1'b1, 1'b0, "simul_done3");
        addRows(1, 4'b0000, 5'd7,  4'b0000, 5'd0, 1'b0, 1'b0, 1'b0, "simul_idle");
        // equal and lower priority requests wait instead of preempting
        addRows(1, 4'b0010, 5'd7,  4'b0000, 5'd0, 1'b0, 1'b0, 1'b0, "low_pend");
        addRows(1, 4'b0000, 5'd7,  4'b0010, 5'd3, 1'b1, 1'b0, 1'b0, "low_grant1");
        addRows(1, 4'b0110, 5'd7,  4'b0010, 5'd3, 1'b1, 1'b0, 1'b0, "low_req");
        addRows(6, 4'b0000, 5'd7,  4'b0010, 5'd3, 1'b1, 1'b0, 1'b0, "low_nopreempt");
        addRows(1, 4'b0000, 5'd7,  4'b0000, 5'd3, 1'b0, 1'b1, 1'b0, "low_done1");
        addRows(8, 4'b0000, 5'd7,  4'b0010, 5'd3, 1'b1, 1'b0, 1'b0, "low_reserve1");
        addRows(1, 4'b0000, 5'd7,  4'b0000, 5'd3, 1'b0, 1'b1, 1'b0, "low_done2");
        addRows(8, 4'b0000, 5'd7,  4'b0100, 5'd7, 1'b1, 1'b0, 1'b0, "low_show2");
        addRows(1, 4'b0000, 5'd7,  4'b0000, 5'd7, 1'b0, 1'b1, 1'b0, "low_done3");
        addRows(1, 4'b0000, 5'd7,  4'b0000, 5'd0, 1'b0, 1'b0, 1'b0, "low_idle");

        #5;
        checkOutput("rst_init", 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge iCLK_50MHZ);
        #1;
        iRST_N = 1'b1;

        foreach (vecs[k]) begin
            code2 = vecs[k].c2;
            applyStimulus(vecs[k].req);
            checkOutput(vecs[k].name, vecs[k].g, vecs[k].sc, vecs[k].b, vecs[k].d, vecs[k].p);
        end
        code2 = 5'd7;

        // preemption by requester 0 at count 4, then requester 2 re-shown in full
        stepCheck(1, 4'b0100, "pre_pend",    4'b0000, 5'd0, 1'b0, 1'b0, 1'b0);
        stepCheck(1, 4'b0000, "pre_grant2",  4'b0100, 5'd7, 1'b1, 1'b0, 1'b0);
        stepCheck(3, 4'b0000, "pre_show2",   4'b0100, 5'd7, 1'b1, 1'b0, 1'b0);
        stepCheck(1, 4'b0001, "pre_reqedge", 4'b0100, 5'd7, 1'b1, 1'b0, 1'b0);
        stepCheck(1, 4'b0000, "pre_take",    4'b0001, 5'd1, 1'b1, 1'b0, 1'b1);
        stepCheck(7, 4'b0000, "pre_show0",   4'b0001, 5'd1, 1'b1, 1'b0, 1'b0);
        stepCheck(1, 4'b0000, "pre_done0",   4'b0000, 5'd1, 1'b0, 1'b1, 1'b0);
        stepCheck(8, 4'b0000, "pre_reshow2", 4'b0100, 5'd7, 1'b1, 1'b0, 1'b0);
        stepCheck(1, 4'b0000, "pre_done2",   4'b0000, 5'd7, 1'b0, 1'b1, 1'b0);
        stepCheck(1, 4'b0000, "pre_idle",    4'b0000, 5'd0, 1'b0, 1'b0, 1'b0);

        // higher request lands so it is seen on the counter==0 edge
        stepCheck(1, 4'b0100, "tie_pend",    4'b0000, 5'd0, 1'b0, 1'b0, 1'b0);
        stepCheck(1, 4'b0000, "tie_grant2",  4'b0100, 5'd7, 1'b1, 1'b0, 1'b0);
        stepCheck(6, 4'b0000, "tie_show2",   4'b0100, 5'd7, 1'b1, 1'b0, 1'b0);
        stepCheck(1, 4'b0001, "tie_reqedge", 4'b0100, 5'd7, 1'b1, 1'b0, 1'b0);
        stepCheck(1, 4'b0000, "tie_take",    4'b0001, 5'd1, 1'b1, 1'b0, 1'b1);
        stepCheck(7, 4'b0000, "tie_show0",   4'b0001, 5'd1, 1'b1, 1'b0, 1'b0);
        stepCheck(1, 4'b0000, "tie_done0",   4'b0000, 5'd1, 1'b0, 1'b1, 1'b0);
        stepCheck(8, 4'b0000, "tie_requeue", 4'b0100, 5'd7, 1'b1, 1'b0, 1'b0);
        stepCheck(1, 4'b0000, "tie_done2",   4'b0000, 5'd7, 1'b0, 1'b1, 1'b0);
        stepCheck(1, 4'b0000, "tie_idle",    4'b0000, 5'd0, 1'b0, 1'b0, 1'b0);

        // requester 3 held high, requester 1 pulsed on the done edge
        stepCheck(1, 4'b1000, "lvl_pend",     4'b0000, 5'd0, 1'b0, 1'b0, 1'b0);
        stepCheck(1, 4'b1000, "lvl_grant3",   4'b1000, 5'd9, 1'b1, 1'b0, 1'b0);
        stepCheck(7, 4'b1000, "lvl_show3",    4'b1000, 5'd9, 1'b1, 1'b0, 1'b0);
        stepCheck(1, 4'b1010, "lvl_done3",    4'b0000, 5'd9, 1'b0, 1'b1, 1'b0);
        stepCheck(1, 4'b1000, "lvl_first1",   4'b0010, 5'd3, 1'b1, 1'b0, 1'b0);
        stepCheck(7, 4'b1000, "lvl_show1",    4'b0010, 5'd3, 1'b1, 1'b0, 1'b0);
        stepCheck(1, 4'b1000, "lvl_done1",    4'b0000, 5'd3, 1'b0, 1'b1, 1'b0);
        stepCheck(8, 4'b1000, "lvl_regrant",  4'b1000, 5'd9, 1'b1, 1'b0, 1'b0);
        stepCheck(1, 4'b1000, "lvl_done3b",   4'b0000, 5'd9, 1'b0, 1'b1, 1'b0);
        stepCheck(4, 4'b1000, "lvl_regrant2", 4'b1000, 5'd9, 1'b1, 1'b0, 1'b0);

        // asynchronous reset mid-show with requester 3 still pending
        req    = 4'b0000;
        iRST_N = 1'b0;
        #2;
        checkOutput("rst_async", 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0);
        stepCheck(2, 4'b0000, "rst_hold", 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0);
        iRST_N = 1'b1;
        stepCheck(12, 4'b0000, "rst_quiet", 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
